serial_to_parallel: RTL and testbench



---
 rtl/serial_to_parallel_if.sv | 23 ++
 rtl/serial_to_parallel.sv | 103 ++++++++++
 tb/tb_serial_to_parallel.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/serial_to_parallel_if.sv
// Serial-in / word-out bundle for the deserializer.
// The master drives the framed serial stream; the slave presents completed words.
interface serial_to_parallel_if #(
    parameter int WIDTH = 8
);
    logic             ser_in;
    logic             ser_valid;
    logic             frame_start;
    logic [WIDTH-1:0] data_out;
    logic             load;
    logic             busy;
    logic             frame_err;

    modport master (
        output ser_in, ser_valid, frame_start,
        input  data_out, load, busy, frame_err
    );

    modport slave (
        input  ser_in, ser_valid, frame_start,
        output data_out, load, busy, frame_err
    );
endinterface

// File: rtl/serial_to_parallel.sv
// Framed serial-to-parallel deserializer: assembles WIDTH accepted bits into a word
// and strobes load for one cycle when it lands in data_out.
module serial_to_parallel #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    serial_to_parallel_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] sr, sr_nxt, sr_base, sr_shift;
    logic [WIDTH-1:0] dout, dout_nxt;
    logic [CW-1:0]    cnt, cnt_nxt, cnt_inc;
    logic             load_q, load_nxt;
    logic             ferr_q, ferr_nxt;
    logic             accept, done;

    // A start bit begins from an empty register so an aborted partial word never leaks in.
    assign sr_base = bus.frame_start ? '0 : sr;

    generate
        if (WIDTH == 1) begin : g_w1
            assign sr_shift = bus.ser_in;
        end else if (MSB_FIRST) begin : g_msb
            assign sr_shift = {sr_base[WIDTH-2:0], bus.ser_in};
        end else begin : g_lsb
            assign sr_shift = {bus.ser_in, sr_base[WIDTH-1:1]};
        end
    endgenerate

    always_comb begin
        state_nxt = state;
        sr_nxt    = sr;
        cnt_nxt   = cnt;
        dout_nxt  = dout;
        load_nxt  = 1'b0;
        ferr_nxt  = 1'b0;

        accept  = bus.ser_valid && ((state == SHIFT) || bus.frame_start);
        cnt_inc = (bus.frame_start ? '0 : cnt) + CW'(1);
        done    = accept && (cnt_inc == CW'(WIDTH));

        case (state)
            IDLE: begin
                // Stray valid bits without a start marker are dropped silently.
                if (accept) begin
                    sr_nxt = sr_shift;
                    if (done) begin
                        dout_nxt = sr_shift;
                        load_nxt = 1'b1;
                        cnt_nxt  = '0;
                    end else begin
                        cnt_nxt   = cnt_inc;
                        state_nxt = SHIFT;
                    end
                end
            end
            SHIFT: begin
                if (bus.ser_valid) begin
                    ferr_nxt = bus.frame_start;
                    sr_nxt   = sr_shift;
                    if (done) begin
                        dout_nxt  = sr_shift;
                        load_nxt  = 1'b1;
                        cnt_nxt   = '0;
                        state_nxt = IDLE;
                    end else begin
                        cnt_nxt = cnt_inc;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            sr     <= '0;
            cnt    <= '0;
            dout   <= '0;
            load_q <= 1'b0;
            ferr_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            sr     <= sr_nxt;
            cnt    <= cnt_nxt;
            dout   <= dout_nxt;
            load_q <= load_nxt;
            ferr_q <= ferr_nxt;
        end
    end

    assign bus.data_out  = dout;
    assign bus.load      = load_q;
    assign bus.busy      = (state == SHIFT);
    assign bus.frame_err = ferr_q;
endmodule

// File: tb/tb_serial_to_parallel.sv
// Directed bench: MSB-first and LSB-first 8-bit deserializers plus a 1-bit instance.
module tb_serial_to_parallel;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    serial_to_parallel_if #(.WIDTH(8)) if8 ();
    serial_to_parallel_if #(.WIDTH(8)) ifl ();
    serial_to_parallel_if #(.WIDTH(1)) if1 ();

    serial_to_parallel #(.WIDTH(8), .MSB_FIRST(1'b1)) dut8 (.clk(clk), .rst(rst), .bus(if8));
    serial_to_parallel #(.WIDTH(8), .MSB_FIRST(1'b0)) dutl (.clk(clk), .rst(rst), .bus(ifl));
    serial_to_parallel #(.WIDTH(1), .MSB_FIRST(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(if1));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of serial input on the selected instance, sample #1 after the edge.
    task automatic drv(input int which, input logic b, input logic fs, input logic sv);
        @(negedge clk);
        if8.ser_in = 1'b0; if8.frame_start = 1'b0; if8.ser_valid = 1'b0;
        ifl.ser_in = 1'b0; ifl.frame_start = 1'b0; ifl.ser_valid = 1'b0;
        if1.ser_in = 1'b0; if1.frame_start = 1'b0; if1.ser_valid = 1'b0;
        case (which)
            0: begin if8.ser_in = b; if8.frame_start = fs; if8.ser_valid = sv; end
            1: begin ifl.ser_in = b; ifl.frame_start = fs; ifl.ser_valid = sv; end
            default: begin if1.ser_in = b; if1.frame_start = fs; if1.ser_valid = sv; end
        endcase
        @(posedge clk);
        #1;
    endtask

    task automatic chk8(input string tag, input logic ld, input logic bz,
                        input logic fe, input logic [7:0] d);
        chk({tag, ".load"}, 32'(if8.load), 32'(ld));
        chk({tag, ".busy"}, 32'(if8.busy), 32'(bz));
        chk({tag, ".ferr"}, 32'(if8.frame_err), 32'(fe));
        chk({tag, ".data"}, 32'(if8.data_out), 32'(d));
    endtask

    initial begin
        logic [7:0] w;
        if8.ser_in = 1'b0; if8.frame_start = 1'b0; if8.ser_valid = 1'b0;
        ifl.ser_in = 1'b0; ifl.frame_start = 1'b0; ifl.ser_valid = 1'b0;
        if1.ser_in = 1'b0; if1.frame_start = 1'b0; if1.ser_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk8("rst8", 1'b0, 1'b0, 1'b0, 8'h00);
        chk("rstl.data", 32'(ifl.data_out), 32'h0);
        chk("rstl.busy", 32'(ifl.busy), 32'h0);
        chk("rst1.load", 32'(if1.load), 32'h0);
        rst = 1'b0;

        // Basic MSB-first capture of 0xA5
        w = 8'hA5;
        for (int i = 7; i >= 0; i--) begin
            drv(0, w[i], i == 7, 1'b1);
            if (i > 0) chk8($sformatf("a5.bit%0d", 7 - i), 1'b0, 1'b1, 1'b0, 8'h00);
        end
        chk8("a5.done", 1'b1, 1'b0, 1'b0, 8'hA5);
        drv(0, 1'b0, 1'b0, 1'b0);
        chk8("a5.after", 1'b0, 1'b0, 1'b0, 8'hA5);

        // LSB-first 0x3C with a 3-cycle gap after bit 3
        w = 8'h3C;
        for (int i = 0; i < 8; i++) begin
            drv(1, w[i], i == 0, 1'b1);
            if (i == 3) begin
                for (int g = 0; g < 3; g++) begin
                    drv(1, 1'b1, 1'b0, 1'b0);
                    chk($sformatf("gap%0d.cnt", g), 32'(dutl.cnt), 32'd4);
                    chk($sformatf("gap%0d.data", g), 32'(ifl.data_out), 32'h0);
                    chk($sformatf("gap%0d.busy", g), 32'(ifl.busy), 32'h1);
                end
            end
            if (i < 7) chk($sformatf("3c.load%0d", i), 32'(ifl.load), 32'h0);
        end
        chk("3c.load", 32'(ifl.load), 32'h1);
        chk("3c.data", 32'(ifl.data_out), 32'h3C);
        drv(1, 1'b0, 1'b0, 1'b0);
        chk("3c.loadoff", 32'(ifl.load), 32'h0);

        // Abort after 5 bits, then 0xF0 starting from the aborting bit
        for (int i = 0; i < 5; i++) begin
            drv(0, 1'b1, i == 0, 1'b1);
            chk8($sformatf("ab.pre%0d", i), 1'b0, 1'b1, 1'b0, 8'hA5);
        end
        w = 8'hF0;
        drv(0, w[7], 1'b1, 1'b1);
        chk8("ab.err", 1'b0, 1'b1, 1'b1, 8'hA5);
        for (int i = 6; i >= 0; i--) begin
            drv(0, w[i], 1'b0, 1'b1);
            if (i > 0) chk8($sformatf("f0.bit%0d", 7 - i), 1'b0, 1'b1, 1'b0, 8'hA5);
        end
        chk8("f0.done", 1'b1, 1'b0, 1'b0, 8'hF0);

        // Reset mid-frame, on an edge that also carries a valid bit
        for (int i = 0; i < 4; i++) drv(0, 1'b1, i == 0, 1'b1);
        chk8("rm.mid", 1'b0, 1'b1, 1'b0, 8'hF0);
        rst = 1'b1;
        drv(0, 1'b1, 1'b0, 1'b1);
        rst = 1'b0;
        chk8("rm.rst", 1'b0, 1'b0, 1'b0, 8'h00);
        chk("rm.cnt", 32'(dut8.cnt), 32'h0);
        for (int i = 0; i < 4; i++) begin
            drv(0, 1'b1, 1'b0, 1'b1);
            chk8($sformatf("rm.rest%0d", i), 1'b0, 1'b0, 1'b0, 8'h00);
        end

        // Back-to-back 0xFF then 0x00, second start in the load cycle
        for (int i = 0; i < 8; i++) drv(0, 1'b1, i == 0, 1'b1);
        chk8("bb.ff", 1'b1, 1'b0, 1'b0, 8'hFF);
        for (int i = 0; i < 8; i++) begin
            drv(0, 1'b0, i == 0, 1'b1);
            if (i < 7) chk8($sformatf("bb.gap%0d", i), 1'b0, 1'b1, 1'b0, 8'hFF);
        end
        chk8("bb.00", 1'b1, 1'b0, 1'b0, 8'h00);

        // Stray valid bits in IDLE
        for (int i = 0; i < 6; i++) begin
            drv(0, i[0], 1'b0, i[0]);
            chk8($sformatf("stray%0d", i), 1'b0, 1'b0, 1'b0, 8'h00);
        end

        // WIDTH=1: every start bit is a complete word
        drv(2, 1'b1, 1'b1, 1'b1);
        chk("w1.load", 32'(if1.load), 32'h1);
        chk("w1.data", 32'(if1.data_out), 32'h1);
        chk("w1.busy", 32'(if1.busy), 32'h0);
        drv(2, 1'b0, 1'b0, 1'b0);
        chk("w1.loadoff", 32'(if1.load), 32'h0);
        chk("w1.hold", 32'(if1.data_out), 32'h1);
        drv(2, 1'b0, 1'b1, 1'b1);
        chk("w1.zero", 32'(if1.data_out), 32'h0);
        chk("w1.load2", 32'(if1.load), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
